// File: rtl/icebus_status_frame_rx.sv
// Parses 19-byte motor-board status frames, checks CRC-16/CCITT-FALSE and strobes one update per good frame.
// Latency 1 cycle from the final CRC byte to upd_valid; no backpressure, a byte may arrive every cycle.
module icebus_status_frame_rx #(
   parameter int NUMBER_OF_MOTORS = 8,
   parameter int TIMEOUT_CYCLES   = 5000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_frame_err,
   output logic        upd_valid,
   output logic [7:0]  upd_motor,
   output logic [23:0] upd_encoder0,
   output logic [23:0] upd_encoder1,
   output logic [23:0] upd_displacement,
   output logic [23:0] upd_duty,
   output logic [31:0] good_frames,
   output logic [31:0] crc_errors,
   output logic [31:0] aborted_frames,
   output logic        in_frame
);

   typedef enum logic [1:0] {HUNT, BODY, CRC_HI, CRC_LO} state_t;
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t            state, state_nxt;
   logic [1:0]        hidx, hidx_nxt;
   logic [3:0]        bidx, bidx_nxt;
   logic [15:0]       crc, crc_nxt;
   logic [7:0]        crc_hi;
   logic [12:0][7:0]  body;
   logic [IDLE_W-1:0] idle_cnt;
   logic              timeout, id_ok;
   logic              ev_good, ev_crc_err, ev_abort, store_body, store_hi;

   function automatic logic [7:0] header_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'hD0;
         2'd1:    return 8'h0D;
         2'd2:    return 8'hBE;
         default: return 8'hEF;
      endcase
   endfunction

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++)
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign id_ok    = ({24'd0, body[0]} < 32'(NUMBER_OF_MOTORS));
   assign timeout  = (state != HUNT) && !rx_valid && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
   assign in_frame = (state != HUNT);

   always_comb begin
      state_nxt  = state;
      hidx_nxt   = hidx;
      bidx_nxt   = bidx;
      crc_nxt    = crc;
      ev_good    = 1'b0;
      ev_crc_err = 1'b0;
      ev_abort   = 1'b0;
      store_body = 1'b0;
      store_hi   = 1'b0;
      // A stop-bit error discards the byte and beats both the byte and the timeout.
      if (rx_frame_err) begin
         ev_abort  = (state != HUNT);
         state_nxt = HUNT;
         hidx_nxt  = 2'd0;
      end else if (rx_valid) begin
         case (state)
            HUNT: begin
               if (rx_data == header_byte(hidx)) begin
                  if (hidx == 2'd3) begin
                     state_nxt = BODY;
                     hidx_nxt  = 2'd0;
                     bidx_nxt  = 4'd0;
                     crc_nxt   = 16'hFFFF;
                  end else begin
                     hidx_nxt = hidx + 2'd1;
                  end
               end else begin
                  hidx_nxt = (rx_data == 8'hD0) ? 2'd1 : 2'd0;
               end
            end
            BODY: begin
               store_body = 1'b1;
               crc_nxt    = crc16_byte(crc, rx_data);
               bidx_nxt   = bidx + 4'd1;
               if (bidx == 4'd12) state_nxt = CRC_HI;
            end
            CRC_HI: begin
               store_hi  = 1'b1;
               state_nxt = CRC_LO;
            end
            default: begin
               state_nxt = HUNT;
               if ({crc_hi, rx_data} != crc) ev_crc_err = 1'b1;
               else if (id_ok)               ev_good    = 1'b1;
               else                          ev_abort   = 1'b1;
            end
         endcase
      end else if (timeout) begin
         state_nxt = HUNT;
         hidx_nxt  = 2'd0;
         ev_abort  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= HUNT;
         hidx             <= 2'd0;
         bidx             <= 4'd0;
         crc              <= 16'hFFFF;
         idle_cnt         <= '0;
         upd_valid        <= 1'b0;
         upd_motor        <= 8'd0;
         upd_encoder0     <= 24'd0;
         upd_encoder1     <= 24'd0;
         upd_displacement <= 24'd0;
         upd_duty         <= 24'd0;
         good_frames      <= 32'd0;
         crc_errors       <= 32'd0;
         aborted_frames   <= 32'd0;
      end else begin
         state     <= state_nxt;
         hidx      <= hidx_nxt;
         bidx      <= bidx_nxt;
         crc       <= crc_nxt;
         upd_valid <= ev_good;
         if (rx_valid)
            idle_cnt <= '0;
         else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES - 1))
            idle_cnt <= idle_cnt + IDLE_W'(1);
         if (ev_good) begin
            upd_motor        <= body[0];
            upd_encoder0     <= {body[1],  body[2],  body[3]};
            upd_encoder1     <= {body[4],  body[5],  body[6]};
            upd_displacement <= {body[7],  body[8],  body[9]};
            upd_duty         <= {body[10], body[11], body[12]};
            good_frames      <= sat_inc(good_frames);
         end
         if (ev_crc_err) crc_errors     <= sat_inc(crc_errors);
         if (ev_abort)   aborted_frames <= sat_inc(aborted_frames);
      end
   end

   // Shadow payload needs no reset: it is only published after a complete frame rewrites it.
   always_ff @(posedge clk) begin
      if (store_body) body[bidx] <= rx_data;
      if (store_hi)   crc_hi     <= rx_data;
   end

endmodule
